// File: rtl/card_access_controller.sv
// rtl/card_access_controller.sv - card read validation, door-open pulse and failure lockout
//
// Purpose: samples the card-read latch level, captures the 18-bit card number
// from the switches, validates it and drives the door actuator and status LEDs.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   card_read_i    level from the card-read latch (asynchronous to clk_i)
//   sw_i[17:0]     [15:0] combination, [17:16] check bits
//   card_number_o  card number captured at the last accepted read
//   door_open_o    high for OPEN_SEC*CLK_HZ cycles after a valid card
//   denied_o       one-cycle pulse after an invalid card
//   locked_out_o   high for LOCKOUT_SEC*CLK_HZ cycles after MAX_FAILS failures
//   fail_count_o   current consecutive-failure count
module card_access_controller #(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          OPEN_SEC    = 2,
    parameter logic [15:0] COMBO       = 16'hA5C3,
    parameter int          MAX_FAILS   = 3,
    parameter int          LOCKOUT_SEC = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        card_read_i,
    input  logic [17:0] sw_i,
    output logic [17:0] card_number_o,
    output logic        door_open_o,
    output logic        denied_o,
    output logic        locked_out_o,
    output logic [2:0]  fail_count_o
);

    localparam int OPEN_CYC = OPEN_SEC * CLK_HZ;
    localparam int LOCK_CYC = LOCKOUT_SEC * CLK_HZ;
    localparam int MAX_CYC  = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
    localparam int TW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYC - 1);
    localparam logic [2:0]    MAX_F     = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        OPEN    = 3'd2,
        DENY    = 3'd3,
        LOCKOUT = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [17:0]   card_number_q, card_number_d;
    logic [2:0]    fail_count_q, fail_count_d;

    logic          s1_q, s2_q, s3_q;
    logic [1:0]    prime_q;
    logic          armed_q;
    logic          rd_edge;
    logic          card_valid;

    // Population count of the combination, modulo 4 (2-bit accumulator wraps).
    function automatic logic [1:0] popcnt_mod4(input logic [15:0] v);
        logic [1:0] c;
        c = 2'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {1'b0, v[i]};
        end
        return c;
    endfunction

    // The synchronizer resets to 0, so a latch that is already high when reset
    // releases would look like a fresh rising edge. prime_q marks when s2_q
    // holds a genuine sample; reads are armed only once a real low is seen.
    assign rd_edge = s2_q & ~s3_q & armed_q;

    assign card_valid = (card_number_q[15:0] == COMBO) &&
                        (card_number_q[17:16] == popcnt_mod4(card_number_q[15:0]));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            card_number_q <= '0;
            fail_count_q  <= '0;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            prime_q       <= 2'b00;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            card_number_q <= card_number_d;
            fail_count_q  <= fail_count_d;
            s1_q          <= card_read_i;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            prime_q       <= {prime_q[0], 1'b1};
            armed_q       <= armed_q | (prime_q[1] & ~s2_q);
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        card_number_d = card_number_q;
        fail_count_d  = fail_count_q;
        case (state_q)
            IDLE: begin
                if (rd_edge) begin
                    card_number_d = sw_i;
                    state_d       = CHECK;
                end
            end
            CHECK: begin
                if (card_valid) begin
                    fail_count_d = '0;
                    timer_d      = OPEN_LOAD;
                    state_d      = OPEN;
                end else begin
                    if (fail_count_q < MAX_F) begin
                        fail_count_d = fail_count_q + 3'd1;
                    end
                    state_d = DENY;
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DENY: begin
                if (fail_count_q == MAX_F) begin
                    timer_d = LOCK_LOAD;
                    state_d = LOCKOUT;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_count_d = '0;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        door_open_o  = 1'b0;
        denied_o     = 1'b0;
        locked_out_o = 1'b0;
        case (state_q)
            OPEN:    door_open_o  = 1'b1;
            DENY:    denied_o     = 1'b1;
            LOCKOUT: locked_out_o = 1'b1;
            default: ;
        endcase
    end

    assign card_number_o = card_number_q;
    assign fail_count_o  = fail_count_q;

endmodule

// File: tb/tb_card_access_controller.sv
// tb/tb_card_access_controller.sv - self-checking bench for card_access_controller
module tb_card_access_controller;

    localparam logic [17:0] VALID = 18'h0A5C3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        card_read;
    logic [17:0] sw;
    logic [17:0] card_number;
    logic        door_open;
    logic        denied;
    logic        locked_out;
    logic [2:0]  fail_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [17:0] sw;
        logic        valid;
        logic [2:0]  fail;
    } vec_t;

    vec_t vecs[6];

    card_access_controller #(
        .CLK_HZ     (10),
        .OPEN_SEC   (2),
        .COMBO      (16'hA5C3),
        .MAX_FAILS  (3),
        .LOCKOUT_SEC(3)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .card_read_i  (card_read),
        .sw_i         (sw),
        .card_number_o(card_number),
        .door_open_o  (door_open),
        .denied_o     (denied),
        .locked_out_o (locked_out),
        .fail_count_o (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Raise card_read; return at the negedge following edge k+3.
    task automatic do_read(input logic [17:0] s);
        @(negedge clk);
        sw = s;
        card_read = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("card_number_k2", 32'(card_number), 32'(s));
        chk("door_low_k2", 32'(door_open), 32'd0);
        chk("denied_low_k2", 32'(denied), 32'd0);
        @(negedge clk);
    endtask

    // Count remaining high cycles of door_open, starting from one already seen.
    task automatic count_door(output int n);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (door_open) n++;
            else break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw;

        vecs[0] = '{sw: 18'h0A5C3, valid: 1'b1, fail: 3'd0};
        vecs[1] = '{sw: 18'h1A5C3, valid: 1'b0, fail: 3'd1};
        vecs[2] = '{sw: 18'h3A5C2, valid: 1'b0, fail: 3'd2};
        vecs[3] = '{sw: 18'h0A5C3, valid: 1'b1, fail: 3'd0};
        vecs[4] = '{sw: 18'h2A5C3, valid: 1'b0, fail: 3'd1};
        vecs[5] = '{sw: 18'h0A5C3, valid: 1'b1, fail: 3'd0};

        // Reset with the latch already high.
        rst_n = 1'b0;
        card_read = 1'b1;
        sw = VALID;
        repeat (3) @(negedge clk);
        chk("rst_card_number", 32'(card_number), 32'd0);
        chk("rst_door_open", 32'(door_open), 32'd0);
        chk("rst_denied", 32'(denied), 32'd0);
        chk("rst_locked_out", 32'(locked_out), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (door_open || denied) saw = 1'b1;
        end
        chk("held_read_no_event", 32'(saw), 32'd0);
        chk("held_read_no_capture", 32'(card_number), 32'd0);
        card_read = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven single reads (includes two failures then a valid card).
        for (int r = 0; r < 6; r++) begin
            do_read(vecs[r].sw);
            chk($sformatf("row%0d_door", r), 32'(door_open), 32'(vecs[r].valid));
            chk($sformatf("row%0d_denied", r), 32'(denied), 32'(!vecs[r].valid));
            chk($sformatf("row%0d_fail", r), 32'(fail_count), 32'(vecs[r].fail));
            card_read = 1'b0;
            if (vecs[r].valid) begin
                count_door(n);
                chk($sformatf("row%0d_open_len", r), 32'(n), 32'd20);
            end else begin
                @(negedge clk);
                chk($sformatf("row%0d_denied_1cyc", r), 32'(denied), 32'd0);
                chk($sformatf("row%0d_no_lock", r), 32'(locked_out), 32'd0);
            end
            repeat (4) @(negedge clk);
        end

        // Reset during OPEN at cycle 10.
        do_read(VALID);
        chk("rstopen_door", 32'(door_open), 32'd1);
        card_read = 1'b0;
        repeat (9) @(negedge clk);
        chk("rstopen_door_c10", 32'(door_open), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstopen_door_async", 32'(door_open), 32'd0);
        chk("rstopen_card_number", 32'(card_number), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Lockout: three wrong cards.
        for (int r = 1; r <= 3; r++) begin
            do_read(18'h00000);
            chk($sformatf("lock_denied%0d", r), 32'(denied), 32'd1);
            chk($sformatf("lock_fail%0d", r), 32'(fail_count), 32'(r));
            card_read = 1'b0;
            if (r < 3) repeat (5) @(negedge clk);
        end
        @(negedge clk);
        chk("lock_start", 32'(locked_out), 32'd1);
        chk("lock_denied_drop", 32'(denied), 32'd0);
        n = 1;
        sw = VALID;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (i == 15) begin
                chk("lock_fail_hold", 32'(fail_count), 32'd3);
                chk("lock_ignored_read", 32'(card_number), 32'd0);
                chk("lock_no_door", 32'(door_open), 32'd0);
            end
            if (locked_out) n++;
            else break;
            if (i == 5) card_read = 1'b1;
            if (i == 10) card_read = 1'b0;
        end
        chk("lock_len", 32'(n), 32'd30);
        chk("lock_end_fail", 32'(fail_count), 32'd0);
        chk("lock_end_door", 32'(door_open), 32'd0);
        repeat (4) @(negedge clk);
        do_read(VALID);
        chk("post_lock_door", 32'(door_open), 32'd1);
        card_read = 1'b0;
        count_door(n);
        chk("post_lock_open_len", 32'(n), 32'd20);
        repeat (4) @(negedge clk);

        // Re-trigger during OPEN is ignored.
        do_read(VALID);
        chk("retrig_door", 32'(door_open), 32'd1);
        card_read = 1'b0;
        n = 1;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (door_open) n++;
            else break;
            if (i == 3) begin
                sw = 18'h00000;
                card_read = 1'b1;
            end
            if (i == 8) card_read = 1'b0;
        end
        chk("retrig_open_len", 32'(n), 32'd20);
        chk("retrig_card_number", 32'(card_number), 32'(VALID));
        chk("retrig_no_deny", 32'(denied), 32'd0);
        repeat (4) @(negedge clk);
        chk("retrig_idle_door", 32'(door_open), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/card_access_controller.md
Name: card_access_controller

Overview:
- Downstream consumer of the push-button card-read latch.
- Samples the latch's level output `card_read`, captures the 18-bit card number from the slide switches, and validates it: 16-bit combination plus 2 check bits.
- Valid card: drives a 2-second door-open pulse.
- Invalid card: counts failures and, after repeated failures, enters a timed lockout.
- Feeds the door actuator and the board status LEDs.

Parameters:
- CLK_HZ, 50_000_000: clock frequency in Hz.
- OPEN_SEC, 2: door-open pulse length in seconds.
- COMBO, 16'hA5C3: stored valid combination.
- MAX_FAILS, 3: consecutive failures that trigger lockout (1..7).
- LOCKOUT_SEC, 10: lockout duration in seconds.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- card_read, input, 1: level from the card-read latch; asynchronous to clk.
- sw, input, 18: slide switches. [15:0] combination, [17:16] check bits.
- card_number, output, 18: card number captured at the last accepted read.
- door_open, output, 1: high for exactly OPEN_SEC*CLK_HZ cycles on a valid card.
- denied, output, 1: one-cycle pulse on an invalid card.
- locked_out, output, 1: high for the whole lockout period.
- fail_count, output, 3: current consecutive-failure count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - card_number=0, door_open=0, denied=0, locked_out=0, fail_count=0.
  - Synchronizer flops and timer cleared.
  - Reset mid-OPEN or mid-LOCKOUT aborts immediately; door_open and locked_out drop asynchronously.
- Input conditioning:
  - card_read passes through 2 flops (s1, s2), then a third flop s3.
  - rd_edge = s2 & ~s3.
  - sw is assumed static while card_read rises; sw is not synchronized.
- Check rule: card valid iff sw[15:0]==COMBO AND sw[17:16] == (popcount(sw[15:0]) mod 4).
- State machine (IDLE, CHECK, OPEN, DENY, LOCKOUT):
  - IDLE:
    - On rd_edge: card_number <= sw, go to CHECK.
    - Otherwise stay.
  - CHECK (1 cycle), evaluates the captured card_number (not live sw):
    - Valid: fail_count <= 0, timer <= OPEN_CYC-1, go to OPEN.
    - Invalid: fail_count <= fail_count+1, go to DENY.
  - OPEN:
    - door_open=1.
    - Timer decrements each cycle; at 0, go to IDLE.
    - door_open is high exactly OPEN_CYC = OPEN_SEC*CLK_HZ cycles.
  - DENY (1 cycle):
    - denied=1.
    - If fail_count==MAX_FAILS: timer <= LOCK_CYC-1, go to LOCKOUT.
    - Otherwise go to IDLE.
  - LOCKOUT:
    - locked_out=1.
    - Timer decrements; at 0: fail_count <= 0, go to IDLE.
    - locked_out is high exactly LOCK_CYC = LOCKOUT_SEC*CLK_HZ cycles.
- Outputs are decoded from registered state; no combinational path from inputs to outputs.
- Latency: if clock edge k first samples card_read=1, card_number updates at edge k+2 and door_open/denied rise at edge k+3.
- Ignored events:
  - rd_edge in CHECK, OPEN, DENY or LOCKOUT is ignored and not queued.
  - card_read held high produces no further reads.
  - A new read requires card_read to fall (latch cleared) and rise again, giving a new rd_edge.
- Timer:
  - Width is $clog2(max(OPEN_CYC, LOCK_CYC)).
  - Counts down to 0; no wrap.
- fail_count:
  - Saturates at MAX_FAILS; never exceeds it.
  - Cleared by a valid card or by the end of lockout.
- Glitches on card_read shorter than one clock may be missed; this is acceptable.

Test Plan:
All scenarios use CLK_HZ=10, OPEN_SEC=2 (OPEN_CYC=20), LOCKOUT_SEC=3 (LOCK_CYC=30), COMBO=16'hA5C3 (popcount 8, check=0).
- Reset: hold rst_n=0 with card_read=1 -> all outputs 0. Release rst_n -> no read occurs until card_read falls and rises again.
- Valid card: sw=18'h0A5C3, card_read rises, edge k samples 1 -> card_number=18'h0A5C3 at k+2; door_open high edges k+3..k+22 (20 cycles); denied stays 0.
- Check-bit mismatch: sw=18'h1A5C3 -> denied one-cycle pulse at k+3, fail_count=1, door_open stays 0.
- Lockout: three wrong cards (sw=18'h00000) -> third gives denied pulse, then locked_out high 30 cycles, fail_count=3 during lockout. A fourth valid read during lockout is ignored. After lockout, fail_count=0; a valid read then opens the door.
- Re-trigger and reset during OPEN: second card_read toggle during OPEN -> pulse length remains 20 cycles and card_number unchanged. Separately, rst_n=0 at OPEN cycle 10 -> door_open drops immediately.
- Success clears failures: two wrong cards then a valid card -> door_open pulse and fail_count returns to 0.
